// File: rtl/gsim_conv_drain_if.sv
// Handshake bundle between the GSIM update core, the convergence monitor and the result consumer.
interface gsim_conv_drain_if #(
    parameter int unsigned W      = 32,
    parameter int unsigned ITER_W = 8,
    parameter int unsigned IDX_W  = 4
);
    logic              start;
    logic              x_valid;
    logic [IDX_W-1:0]  x_idx;
    logic [W-1:0]      x_in;
    logic              conv_done;
    logic              out_valid;
    logic [W-1:0]      x_out;
    logic [ITER_W-1:0] iter_cnt;

    modport master (
        output start, x_valid, x_idx, x_in,
        input  conv_done, out_valid, x_out, iter_cnt
    );

    modport slave (
        input  start, x_valid, x_idx, x_in,
        output conv_done, out_valid, x_out, iter_cnt
    );
endinterface

// File: rtl/gsim_conv_drain.sv
// Gauss-Seidel convergence monitor: tracks per-sweep max element change, decides
// convergence or iteration cap, then streams the final vector out one element per cycle.
module gsim_conv_drain #(
    parameter int unsigned  N        = 16,
    parameter int unsigned  W        = 32,
    parameter logic [W-1:0] TOL      = 32'd4,
    parameter int unsigned  MAX_ITER = 100,
    parameter int unsigned  ITER_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    gsim_conv_drain_if.slave  gsim
);
    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [W:0]  TOL_X = {1'b0, TOL};

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        xr_q [N];
    logic [W-1:0]        xr_d [N];
    logic [W:0]          max_d_q, max_d_d;
    logic                first_q, first_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                conv_q, conv_d;
    logic                out_valid_q, out_valid_d;
    logic [W-1:0]        x_out_q, x_out_d;

    logic [W:0]          x_ext, r_ext, diff, abs_d, max_nx;
    logic [ITER_W-1:0]   iter_inc;
    logic                converged, capped;

    // Sign-extend to W+1 so the difference of any two W-bit values fits without wrap.
    always_comb begin
        x_ext    = {gsim.x_in[W-1], gsim.x_in};
        r_ext    = {xr_q[gsim.x_idx][W-1], xr_q[gsim.x_idx]};
        diff     = x_ext - r_ext;
        abs_d    = diff[W] ? -diff : diff;
        max_nx   = (abs_d > max_d_q) ? abs_d : max_d_q;
        iter_inc = iter_q + ITER_W'(1);
        converged = !first_q && (max_nx <= TOL_X);
        capped    = (iter_inc == ITER_W'(MAX_ITER));
    end

    always_comb begin
        state_d     = state_q;
        xr_d        = xr_q;
        max_d_d     = max_d_q;
        first_d     = first_q;
        cnt_d       = cnt_q;
        iter_d      = iter_q;
        conv_d      = conv_q;
        out_valid_d = 1'b0;
        x_out_d     = x_out_q;

        unique case (state_q)
            IDLE: begin
            end

            COLLECT: begin
                if (gsim.x_valid) begin
                    xr_d[gsim.x_idx] = gsim.x_in;
                    max_d_d          = max_nx;
                    if (gsim.x_idx == IDX_W'(N - 1)) begin
                        iter_d = iter_inc;
                        if (converged || capped) begin
                            state_d     = DRAIN;
                            conv_d      = 1'b1;
                            cnt_d       = '0;
                            out_valid_d = 1'b1;
                            x_out_d     = xr_d[0];
                        end else begin
                            max_d_d = '0;
                            first_d = 1'b0;
                        end
                    end
                end
            end

            // cnt_q names the element currently on x_out; preload the next one.
            DRAIN: begin
                if (cnt_q == IDX_W'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d       = cnt_q + IDX_W'(1);
                    out_valid_d = 1'b1;
                    x_out_d     = xr_q[cnt_d];
                end
            end

            DONE: begin
            end

            default: state_d = IDLE;
        endcase

        if (gsim.start) begin
            for (int unsigned i = 0; i < N; i++) begin
                xr_d[i] = '0;
            end
            state_d     = COLLECT;
            max_d_d     = '0;
            first_d     = 1'b1;
            cnt_d       = '0;
            iter_d      = '0;
            conv_d      = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int unsigned i = 0; i < N; i++) begin
                xr_q[i] <= '0;
            end
            max_d_q     <= '0;
            first_q     <= 1'b1;
            cnt_q       <= '0;
            iter_q      <= '0;
            conv_q      <= 1'b0;
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            for (int unsigned i = 0; i < N; i++) begin
                xr_q[i] <= xr_d[i];
            end
            max_d_q     <= max_d_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            iter_q      <= iter_d;
            conv_q      <= conv_d;
            out_valid_q <= out_valid_d;
            x_out_q     <= x_out_d;
        end
    end

    assign gsim.conv_done = conv_q;
    assign gsim.out_valid = out_valid_q;
    assign gsim.x_out     = x_out_q;
    assign gsim.iter_cnt  = iter_q;

endmodule
